// File: rtl/slave_fabric.sv
// slave_fabric: single-master to NSLAVE-slave bus bridge.
//   clk, reset           : clock and synchronous active-high reset
//   m_req/m_addr/m_wdata/m_rw_ : master request, sampled only when idle
//   m_ack/m_err/m_rdata/m_busy : master completion pulse, error, read data, busy
//   s_cs_/s_addr/s_wdata/s_rw_ : latched slave-side request, one active-low select
//   s_rdata/s_rdy        : packed per-slave read data and ready
// The top SEL_WIDTH address bits pick the slave; unmapped indices and slaves
// that stay not-ready for TIMEOUT cycles complete with m_err.
module slave_fabric #(
  parameter int BUS_ADDR_WIDTH = 30,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 2,
  parameter int NSLAVE         = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_req,
  input  logic [BUS_ADDR_WIDTH-1:0]    m_addr,
  input  logic [DATA_WIDTH-1:0]        m_wdata,
  input  logic                         m_rw_,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [DATA_WIDTH-1:0]        m_rdata,
  output logic                         m_busy,
  output logic [NSLAVE-1:0]            s_cs_,
  output logic [MEM_ADDR_WIDTH-1:0]    s_addr,
  output logic [DATA_WIDTH-1:0]        s_wdata,
  output logic                         s_rw_,
  input  logic [NSLAVE*DATA_WIDTH-1:0] s_rdata,
  input  logic [NSLAVE-1:0]            s_rdy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_WIDTH:0] NSLAVE_W = (SEL_WIDTH + 1)'(NSLAVE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [SEL_WIDTH-1:0]    sel_in;
  logic                    mapped_in;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    wait_last;
  logic                    err_q;
  logic                    rdy_sel;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic                    addr_unused;

  assign sel_in      = m_addr[BUS_ADDR_WIDTH-1 -: SEL_WIDTH];
  assign mapped_in   = {1'b0, sel_in} < NSLAVE_W;
  assign wait_last   = (wait_cnt == CNT_W'(TIMEOUT - 1));
  // Address bits between the slave index and the slave-local field are not decoded.
  assign addr_unused = ^m_addr;

  // Only the latched slave's ready and data are ever looked at.
  always_comb begin
    rdy_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        rdy_sel   = s_rdy[i];
        rdata_sel = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s_cs_ = '1;
    if (state_q == ACCESS) begin
      for (int unsigned i = 0; i < NSLAVE; i++) begin
        if (sel_q == SEL_WIDTH'(i)) s_cs_[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_req) state_d = mapped_in ? ACCESS : RESP;
      ACCESS:  if (rdy_sel || wait_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_ack  = (state_q == RESP);
  assign m_err  = (state_q == RESP) && err_q;
  assign m_busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      m_rdata  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_rw_    <= 1'b1;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (m_req) begin
            s_addr   <= m_addr[MEM_ADDR_WIDTH-1:0];
            s_wdata  <= m_wdata;
            s_rw_    <= m_rw_;
            sel_q    <= sel_in;
            wait_cnt <= '0;
            err_q    <= !mapped_in;
            // Unmapped reads skip ACCESS, so their zero data is loaded here.
            if (!mapped_in && m_rw_) m_rdata <= '0;
          end
        end
        ACCESS: begin
          if (rdy_sel) begin
            err_q <= 1'b0;
            if (s_rw_) m_rdata <= rdata_sel;
          end else if (wait_last) begin
            err_q <= 1'b1;
            if (s_rw_) m_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/slave_fabric.md
SLAVE_FABRIC -- requirements
Module: slave_fabric

Interface
REQ-001 Parameter BUS_ADDR_WIDTH, default 30: master address width.
REQ-002 Parameter MEM_ADDR_WIDTH, default 16: slave-local address width, with MEM_ADDR_WIDTH <= BUS_ADDR_WIDTH-SEL_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32: data width.
REQ-004 Parameter SEL_WIDTH, default 2: number of top address bits used as slave index.
REQ-005 Parameter NSLAVE, default 4: number of attached slaves, 1..2^SEL_WIDTH.
REQ-006 Parameter TIMEOUT, default 16: maximum number of ACCESS cycles before a bus error, >= 1.
REQ-007 clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 m_req  in  1  master request, sampled only in IDLE.
REQ-010 m_addr  in  BUS_ADDR_WIDTH  master address.
REQ-011 m_wdata  in  DATA_WIDTH  master write data.
REQ-012 m_rw_  in  1  1 = read, 0 = write.
REQ-013 m_ack  out  1  one-cycle completion pulse.
REQ-014 m_err  out  1  error flag, valid only with m_ack.
REQ-015 m_rdata  out  DATA_WIDTH  registered read data.
REQ-016 m_busy  out  1  high whenever the state is not IDLE.
REQ-017 s_cs_  out  NSLAVE  per-slave chip select, active-low, at most one bit low.
REQ-018 s_addr  out  MEM_ADDR_WIDTH  latched m_addr[MEM_ADDR_WIDTH-1:0].
REQ-019 s_wdata  out  DATA_WIDTH  latched write data.
REQ-020 s_rw_  out  1  latched m_rw_.
REQ-021 s_rdata  in  NSLAVE*DATA_WIDTH  slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-022 s_rdy  in  NSLAVE  per-slave ready, active-high.

Function
REQ-023 The block SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-024 Slave index sel SHALL be m_addr[BUS_ADDR_WIDTH-1 -: SEL_WIDTH].
REQ-025 In IDLE with m_req=1 at edge E, the block SHALL latch addr, wdata, rw_ and sel.
- If sel < NSLAVE: go to ACCESS and clear the wait counter.
- Otherwise (unmapped): go to RESP with m_err=1 and no chip select.
REQ-026 During ACCESS, s_cs_[sel] SHALL be 0 and all other s_cs_ bits 1; in IDLE and RESP all s_cs_ bits SHALL be 1.
REQ-027 In ACCESS, s_rdy[sel]=1 at an edge SHALL move the FSM to RESP with m_err=0.
- On a read, m_rdata SHALL capture slave sel's s_rdata at that same edge.
REQ-028 In ACCESS with s_rdy[sel]=0 and the wait counter equal to TIMEOUT-1, the FSM SHALL go to RESP with m_err=1; otherwise the counter SHALL increment.
REQ-029 s_rdy bits of unselected slaves SHALL be ignored.
REQ-030 In RESP, m_ack SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE at the next edge.
- m_req SHALL be ignored in ACCESS and RESP.
REQ-031 Latency, ready tied high: request sampled at E -> cs_ low in cycle E..E+1 -> m_ack high in cycle E+1..E+2 -> next request accepted at E+3 at the earliest.
REQ-032 m_rdata SHALL hold its value across write transactions.
- m_rdata SHALL load 0 on an erroring read, whether unmapped or timed out.
REQ-033 m_err SHALL be 0 whenever m_ack is 0.
REQ-034 Changes to m_addr, m_wdata or m_rw_ after acceptance SHALL NOT affect s_addr, s_wdata, s_rw_ or sel.

Reset
REQ-035 With reset=1 at an edge, the block SHALL set: state IDLE, m_ack=0, m_err=0, m_busy=0, m_rdata=0, s_cs_ all ones, wait counter 0.
- s_addr, s_wdata and s_rw_ SHALL reset to 0, 0 and 1 respectively.
REQ-036 Reset SHALL take priority over every other event, including reset asserted mid-ACCESS.
- A transaction aborted by reset SHALL produce no m_ack.

Verification
REQ-037 Read, slave 1 ready immediately: m_addr=0x1000_0004, m_rw_=1, s_rdata slice 1=0xDEADBEEF, s_rdy=4'b1111 -> s_cs_=4'b1101 for 1 cycle, then m_ack=1, m_err=0, m_rdata=0xDEADBEEF.
REQ-038 Write with wait states: m_addr=0x0000_0010, m_wdata=0x12345678, m_rw_=0, s_rdy[0] rising after 3 ACCESS cycles -> s_cs_[0]=0 for 4 cycles, s_addr=0x0010, s_wdata=0x12345678, then m_ack=1, m_err=0, m_rdata unchanged.
REQ-039 Timeout: read of slave 2 with s_rdy=0, TIMEOUT=16 -> s_cs_[2]=0 for exactly 16 cycles, then m_ack=1, m_err=1, m_rdata=0.
REQ-040 Unmapped, NSLAVE=3: m_addr=0x3000_0000 -> no s_cs_ bit low, m_ack=1 and m_err=1 one cycle after acceptance.
REQ-041 Reset mid-ACCESS: reset=1 during the 2nd wait cycle -> next cycle s_cs_ all ones, m_busy=0, no m_ack; a subsequent read completes normally.
REQ-042 Back-to-back: m_req held high for 10 cycles with s_rdy all ones -> one accepted transaction every 3 cycles, with m_ack pulses separated by 2 low cycles.
